// File: rtl/real_mul_arbiter.sv
// Round-robin front end that shares one pipelined real_mul between NUM_REQ requesters.
// A valid/id tag travels beside the multiplier so each result returns to its issuer.
module real_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int MUL_LAT = 1,
   parameter int W       = 64,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*W-1:0] req_op1,
   input  logic [NUM_REQ*W-1:0] req_op2,
   output logic [W-1:0]         mul_op1,
   output logic [W-1:0]         mul_op2,
   input  logic [W-1:0]         mul_result,
   output logic [NUM_REQ-1:0]   resp_valid,
   output logic [W-1:0]         resp_data,
   output logic [ID_W-1:0]      grant_id,
   output logic [3:0]           inflight
);

   logic [NUM_REQ-1:0]          win;
   logic [ID_W-1:0]             win_id;
   logic                        found;
   logic                        hs;
   logic                        resp;
   // Stage 0 lines up with the operand registers; stage MUL_LAT with mul_result.
   logic [MUL_LAT:0]            vld_pipe;
   logic [MUL_LAT:0][ID_W-1:0]  id_pipe;

   function automatic logic [ID_W-1:0] rr_id(input logic [ID_W-1:0] g, input int k);
      return ID_W'((int'(g) + k) % NUM_REQ);
   endfunction

   always_comb begin
      win    = '0;
      win_id = grant_id;
      found  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && req_valid[rr_id(grant_id, k)]) begin
            found               = 1'b1;
            win_id              = rr_id(grant_id, k);
            win[win_id]         = 1'b1;
         end
      end
   end

   assign req_ready = en ? win : '0;
   assign hs        = en & found;
   assign resp      = vld_pipe[MUL_LAT];

   always_comb begin
      resp_valid = '0;
      if (resp) resp_valid[id_pipe[MUL_LAT]] = 1'b1;
   end

   assign resp_data = mul_result;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_op1  <= '0;
         mul_op2  <= '0;
         grant_id <= ID_W'(NUM_REQ - 1);
         vld_pipe <= '0;
         id_pipe  <= '0;
         inflight <= '0;
      end else begin
         if (hs) begin
            mul_op1  <= req_op1[win_id*W +: W];
            mul_op2  <= req_op2[win_id*W +: W];
            grant_id <= win_id;
         end
         vld_pipe <= {vld_pipe[MUL_LAT-1:0], hs};
         id_pipe  <= {id_pipe[MUL_LAT-1:0], win_id};
         if (hs && !resp)      inflight <= inflight + 4'd1;
         else if (!hs && resp) inflight <= inflight - 4'd1;
      end
   end

endmodule

// File: tb/tb_real_mul_arbiter.sv
// Randomized bench for real_mul_arbiter: a queue-based model of round-robin issue and
// in-order, fixed-latency returns is compared against the DUT every cycle.
module tb_real_mul_arbiter;
   localparam int N   = 4;
   localparam int LAT = 2;
   localparam int W   = 64;
   localparam int IW  = $clog2(N);

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [N-1:0]      v;
   logic [N-1:0]      req_ready;
   logic [N-1:0][W-1:0] a, b;
   logic [W-1:0]      mul_op1, mul_op2, mul_result, resp_data;
   logic [N-1:0]      resp_valid;
   logic [IW-1:0]     grant_id;
   logic [3:0]        inflight;

   real_mul_arbiter #(.NUM_REQ(N), .MUL_LAT(LAT), .W(W)) dut (
      .clk(clk), .rst(rst), .en(en), .req_valid(v), .req_ready(req_ready),
      .req_op1(a), .req_op2(b), .mul_op1(mul_op1), .mul_op2(mul_op2),
      .mul_result(mul_result), .resp_valid(resp_valid), .resp_data(resp_data),
      .grant_id(grant_id), .inflight(inflight)
   );

   always #5 clk = ~clk;

   // Stand-in multiplier: LAT-clock pipelined product of the registered operands.
   logic [W-1:0] mp [LAT];
   initial for (int k = 0; k < LAT; k++) mp[k] = '0;
   always @(posedge clk) begin
      mp[0] <= mul_op1 * mul_op2;
      for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
   end
   assign mul_result = mp[LAT-1];

   typedef struct {
      int          id;
      logic [W-1:0] d;
      int          due;
   } ent_t;

   ent_t         q[$];
   int           last;
   int           ecnt;
   logic [W-1:0] m_op1, m_op2;
   int           errs   = 0;
   int           checks = 0;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic new_ops(input int i);
      a[i] = {$urandom, $urandom};
      b[i] = {$urandom, $urandom};
   endtask

   // One clock: check at negedge, update model at posedge, drive new inputs just after.
   task automatic cyc(input int pct, input logic [N-1:0] mask, input bit drop);
      int w;
      logic [N-1:0] er;
      logic hs;
      @(negedge clk);
      w = -1;
      for (int k = 1; k <= N; k++)
         if (w < 0 && v[(last + k) % N]) w = (last + k) % N;
      er = '0;
      if (en && w >= 0) er[w] = 1'b1;
      chk("ready", W'(req_ready), W'(er));
      chk("inflight", W'(inflight), W'(q.size()));
      chk("grant", W'(grant_id), W'(last));
      chk("op1", mul_op1, m_op1);
      chk("op2", mul_op2, m_op2);
      if (q.size() > 0 && q[0].due == ecnt) begin
         er = '0;
         er[q[0].id] = 1'b1;
         chk("rvalid", W'(resp_valid), W'(er));
         chk("rdata", resp_data, q[0].d);
         void'(q.pop_front());
      end else begin
         chk("rvalid", W'(resp_valid), '0);
      end
      hs = en && (w >= 0);
      @(posedge clk);
      ecnt++;
      if (hs) begin
         last  = w;
         m_op1 = a[w];
         m_op2 = b[w];
         q.push_back('{w, a[w] * b[w], ecnt + LAT});
      end
      #1;
      for (int i = 0; i < N; i++) begin
         if (!v[i] || (hs && w == i)) begin
            v[i] = mask[i] && ($urandom_range(0, 99) < pct);
            if (v[i]) new_ops(i);
         end else if (drop && $urandom_range(0, 15) == 0) begin
            v[i] = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      q.delete();
      last  = N - 1;
      m_op1 = '0;
      m_op2 = '0;
   endtask

   initial begin
      rst = 1'b0;
      en  = 1'b0;
      v   = '0;
      a   = '0;
      b   = '0;
      ecnt = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_inflight", W'(inflight), '0);
      chk("rst_rvalid", W'(resp_valid), '0);
      chk("rst_grant", W'(grant_id), W'(N - 1));
      chk("rst_op1", mul_op1, '0);
      @(posedge clk);
      #1 rst = 1'b1;
      en = 1'b1;

      // Requester 0 alone: first grant goes to it.
      v[0] = 1'b1; a[0] = 64'h3F800000; b[0] = 64'h3F800000;
      repeat (6) cyc(0, 4'b0001, 0);
      // Full contention: strict rotation, every product routed home.
      repeat (40) cyc(100, 4'b1111, 0);
      // Single requester back-to-back.
      repeat (6) cyc(0, 4'b0000, 0);
      repeat (20) cyc(100, 4'b0010, 0);
      // Random traffic with withdrawals.
      repeat (300) cyc(50, 4'b1111, 1);
      // Grants disabled while ops drain, then resumed.
      en = 1'b0;
      repeat (15) cyc(60, 4'b1001, 0);
      en = 1'b1;
      repeat (15) cyc(60, 4'b1001, 0);
      repeat (100) cyc(70, 4'b1111, 1);

      // Asynchronous reset with work in flight.
      repeat (4) cyc(100, 4'b1111, 0);
      #2 rst = 1'b0;
      v = '0;
      #1;
      chk("arst_inflight", W'(inflight), '0);
      chk("arst_rvalid", W'(resp_valid), '0);
      chk("arst_grant", W'(grant_id), W'(N - 1));
      chk("arst_op1", mul_op1, '0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (6) cyc(0, 4'b0000, 0);
      repeat (300) cyc(60, 4'b1111, 1);
      repeat (LAT + 3) cyc(0, 4'b0000, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
